// File: rtl/let_frame_parser.sv
// Command-frame parser: AA 55 CMD LEN_H LEN_L DATA[LEN] CHK, with CHK the 8-bit sum of CMD..DATA.
// Payload bytes are streamed with their index; frame end reports cmd_done or cmd_error.
module let_frame_parser #(
   parameter int unsigned MAX_PAYLOAD_LEN = 256,
   parameter int unsigned TIMEOUT_CYCLES  = 100000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  usb_data_in,
   input  logic        usb_data_valid_in,
   output logic [7:0]  cmd_out,
   output logic [15:0] cmd_length,
   output logic        cmd_start,
   output logic [7:0]  payload_data,
   output logic        payload_valid,
   output logic [15:0] payload_index,
   output logic        cmd_done,
   output logic        cmd_error,
   output logic        busy
);

   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SOF2,
      S_CMD,
      S_LEN_H,
      S_LEN_L,
      S_DATA,
      S_CHK
   } state_t;

   state_t        state, state_nxt;
   logic [7:0]    chk, chk_nxt;
   logic [15:0]   count, count_nxt;
   logic [TW-1:0] tmo, tmo_nxt;
   logic [7:0]    cmd_out_nxt, payload_data_nxt;
   logic [15:0]   cmd_length_nxt, payload_index_nxt, len_full;
   logic          cmd_start_nxt, payload_valid_nxt, cmd_done_nxt, cmd_error_nxt;

   assign len_full = {cmd_length[15:8], usb_data_in};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         chk           <= '0;
         count         <= '0;
         tmo           <= '0;
         cmd_out       <= '0;
         cmd_length    <= '0;
         cmd_start     <= 1'b0;
         payload_data  <= '0;
         payload_valid <= 1'b0;
         payload_index <= '0;
         cmd_done      <= 1'b0;
         cmd_error     <= 1'b0;
         busy          <= 1'b0;
      end else begin
         state         <= state_nxt;
         chk           <= chk_nxt;
         count         <= count_nxt;
         tmo           <= tmo_nxt;
         cmd_out       <= cmd_out_nxt;
         cmd_length    <= cmd_length_nxt;
         cmd_start     <= cmd_start_nxt;
         payload_data  <= payload_data_nxt;
         payload_valid <= payload_valid_nxt;
         payload_index <= payload_index_nxt;
         cmd_done      <= cmd_done_nxt;
         cmd_error     <= cmd_error_nxt;
         busy          <= (state_nxt != S_IDLE);
      end
   end

   always_comb begin
      state_nxt         = state;
      chk_nxt           = chk;
      count_nxt         = count;
      tmo_nxt           = tmo;
      cmd_out_nxt       = cmd_out;
      cmd_length_nxt    = cmd_length;
      payload_data_nxt  = payload_data;
      payload_index_nxt = payload_index;
      cmd_start_nxt     = 1'b0;
      payload_valid_nxt = 1'b0;
      cmd_done_nxt      = 1'b0;
      cmd_error_nxt     = 1'b0;

      if (usb_data_valid_in) begin
         tmo_nxt = '0;
         unique case (state)
            S_IDLE: if (usb_data_in == 8'hAA) state_nxt = S_SOF2;
            S_SOF2: begin
               if (usb_data_in == 8'h55)      state_nxt = S_CMD;
               else if (usb_data_in != 8'hAA) state_nxt = S_IDLE;
            end
            S_CMD: begin
               cmd_out_nxt = usb_data_in;
               chk_nxt     = usb_data_in;
               state_nxt   = S_LEN_H;
            end
            S_LEN_H: begin
               cmd_length_nxt[15:8] = usb_data_in;
               chk_nxt              = chk + usb_data_in;
               state_nxt            = S_LEN_L;
            end
            S_LEN_L: begin
               cmd_length_nxt[7:0] = usb_data_in;
               chk_nxt             = chk + usb_data_in;
               count_nxt           = '0;
               cmd_start_nxt       = 1'b1;
               if (len_full == 16'd0) begin
                  state_nxt = S_CHK;
               end else if (32'(len_full) > 32'(MAX_PAYLOAD_LEN)) begin
                  cmd_error_nxt = 1'b1;
                  state_nxt     = S_IDLE;
               end else begin
                  state_nxt = S_DATA;
               end
            end
            S_DATA: begin
               payload_valid_nxt = 1'b1;
               payload_data_nxt  = usb_data_in;
               payload_index_nxt = count;
               chk_nxt           = chk + usb_data_in;
               count_nxt         = count + 16'd1;
               if (count + 16'd1 == cmd_length) state_nxt = S_CHK;
            end
            S_CHK: begin
               if (usb_data_in == chk) cmd_done_nxt  = 1'b1;
               else                    cmd_error_nxt = 1'b1;
               state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
         endcase
      end else if (state != S_IDLE) begin
         // Counter holds the number of idle cycles already elapsed; abort on the last one.
         if (tmo == TW'(TIMEOUT_CYCLES - 1)) begin
            cmd_error_nxt = 1'b1;
            state_nxt     = S_IDLE;
            tmo_nxt       = '0;
         end else begin
            tmo_nxt = tmo + TW'(1);
         end
      end else begin
         tmo_nxt = '0;
      end
   end

endmodule

// File: tb/tb_let_frame_parser.sv
// Directed bench for let_frame_parser: known frames with hand-computed checksums and pulse counts.
module tb_let_frame_parser;

   localparam int unsigned TMO = 20;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  usb_data_in = 8'h00;
   logic        usb_data_valid_in = 1'b0;
   logic [7:0]  cmd_out;
   logic [15:0] cmd_length;
   logic        cmd_start;
   logic [7:0]  payload_data;
   logic        payload_valid;
   logic [15:0] payload_index;
   logic        cmd_done;
   logic        cmd_error;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;

   // negedge monitor: pulse counts and captured payload stream
   logic        mon_en = 1'b0;
   int          np = 0, starts = 0, dones = 0, errs = 0;
   logic [7:0]  pd [0:15];
   logic [15:0] pi [0:15];

   let_frame_parser #(.MAX_PAYLOAD_LEN(256), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .usb_data_in(usb_data_in), .usb_data_valid_in(usb_data_valid_in),
      .cmd_out(cmd_out), .cmd_length(cmd_length), .cmd_start(cmd_start),
      .payload_data(payload_data), .payload_valid(payload_valid), .payload_index(payload_index),
      .cmd_done(cmd_done), .cmd_error(cmd_error), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (mon_en) begin
         if (payload_valid) begin
            if (np < 16) begin
               pd[np] = payload_data;
               pi[np] = payload_index;
            end
            np++;
         end
         if (cmd_start) starts++;
         if (cmd_done)  dones++;
         if (cmd_error) errs++;
      end
   end

   task automatic clear_mon();
      #1;
      np = 0; starts = 0; dones = 0; errs = 0;
      mon_en = 1'b1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      usb_data_in       = b;
      usb_data_valid_in = 1'b1;
   endtask

   // Drops valid at the negedge where the final byte's response is visible.
   task automatic end_bytes();
      @(negedge clk);
      usb_data_valid_in = 1'b0;
   endtask

   task automatic settle();
      repeat (3) @(negedge clk);
      #1;
   endtask

   task automatic send_dsm(input logic [7:0] c);
      send_byte(8'hAA); send_byte(8'h55); send_byte(8'h0A);
      send_byte(8'h00); send_byte(8'h01); send_byte(8'h0F); send_byte(c);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_checks++; if ({cmd_start, payload_valid, cmd_done, cmd_error} !== 4'b0) begin
         n_fail++; $display("FAIL reset_pulses: got %b want 0000", {cmd_start, payload_valid, cmd_done, cmd_error}); end
      n_checks++; if ({cmd_out, cmd_length, payload_data, payload_index} !== 48'h0) begin
         n_fail++; $display("FAIL reset_regs: got %h want 0", {cmd_out, cmd_length, payload_data, payload_index}); end
      rst_n = 1'b1;
   endtask

   task automatic test_heartbeat();
      clear_mon();
      send_byte(8'hAA); send_byte(8'h55); send_byte(8'hFF);
      send_byte(8'h00); send_byte(8'h00); send_byte(8'hFF);
      end_bytes();
      n_checks++; if (cmd_done !== 1'b1) begin n_fail++; $display("FAIL hb_done_timing: got %b want 1", cmd_done); end
      settle();
      n_checks++; if (cmd_out !== 8'hFF) begin n_fail++; $display("FAIL hb_cmd: got %h want ff", cmd_out); end
      n_checks++; if (cmd_length !== 16'h0000) begin n_fail++; $display("FAIL hb_len: got %h want 0000", cmd_length); end
      n_checks++; if (starts !== 1) begin n_fail++; $display("FAIL hb_starts: got %0d want 1", starts); end
      n_checks++; if (np !== 0) begin n_fail++; $display("FAIL hb_payloads: got %0d want 0", np); end
      n_checks++; if (dones !== 1 || errs !== 0) begin
         n_fail++; $display("FAIL hb_result: got done=%0d err=%0d want 1/0", dones, errs); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL hb_busy: got %b want 0", busy); end
   endtask

   task automatic test_pwm();
      logic [7:0] exp_d [0:4];
      exp_d[0] = 8'h01; exp_d[1] = 8'h03; exp_d[2] = 8'hE8; exp_d[3] = 8'h01; exp_d[4] = 8'hF4;
      clear_mon();
      send_byte(8'hAA); send_byte(8'h55); send_byte(8'hFE); send_byte(8'h00); send_byte(8'h05);
      for (int i = 0; i < 5; i++) send_byte(exp_d[i]);
      send_byte(8'hE4);
      end_bytes();
      n_checks++; if (cmd_done !== 1'b1) begin n_fail++; $display("FAIL pwm_done_timing: got %b want 1", cmd_done); end
      settle();
      n_checks++; if (np !== 5) begin n_fail++; $display("FAIL pwm_count: got %0d want 5", np); end
      for (int i = 0; i < 5; i++) begin
         n_checks++; if (pd[i] !== exp_d[i] || pi[i] !== 16'(i)) begin
            n_fail++; $display("FAIL pwm_byte%0d: got %h@%0d want %h@%0d", i, pd[i], pi[i], exp_d[i], i); end
      end
      n_checks++; if (cmd_length !== 16'd5 || cmd_out !== 8'hFE) begin
         n_fail++; $display("FAIL pwm_hdr: got %h/%h want fe/0005", cmd_out, cmd_length); end
      n_checks++; if (dones !== 1 || errs !== 0) begin
         n_fail++; $display("FAIL pwm_result: got done=%0d err=%0d want 1/0", dones, errs); end
   endtask

   task automatic test_dsm();
      clear_mon();
      send_dsm(8'h1A);
      end_bytes();
      n_checks++; if (cmd_done !== 1'b1) begin n_fail++; $display("FAIL dsm_done: got %b want 1", cmd_done); end
      settle();
      n_checks++; if (np !== 1 || pd[0] !== 8'h0F || pi[0] !== 16'd0) begin
         n_fail++; $display("FAIL dsm_payload: got n=%0d %h@%0d want 1 0f@0", np, pd[0], pi[0]); end
      clear_mon();
      send_dsm(8'h1B);
      end_bytes();
      n_checks++; if (cmd_error !== 1'b1 || cmd_done !== 1'b0) begin
         n_fail++; $display("FAIL dsm_badchk: got done=%b err=%b want 0/1", cmd_done, cmd_error); end
      settle();
      n_checks++; if (dones !== 0 || errs !== 1) begin
         n_fail++; $display("FAIL dsm_badchk_cnt: got done=%0d err=%0d want 0/1", dones, errs); end
   endtask

   task automatic test_resync();
      clear_mon();
      send_byte(8'h12); send_byte(8'hAA); send_byte(8'h34);
      send_byte(8'hAA);
      send_dsm(8'h1A);
      end_bytes();
      settle();
      n_checks++; if (dones !== 1 || errs !== 0 || starts !== 1) begin
         n_fail++; $display("FAIL resync: got done=%0d err=%0d start=%0d want 1/0/1", dones, errs, starts); end
      n_checks++; if (np !== 1 || pd[0] !== 8'h0F) begin
         n_fail++; $display("FAIL resync_payload: got n=%0d %h want 1 0f", np, pd[0]); end
   endtask

   task automatic test_len_too_big();
      clear_mon();
      send_byte(8'hAA); send_byte(8'h55); send_byte(8'h01); send_byte(8'h01); send_byte(8'h01);
      end_bytes();
      n_checks++; if (cmd_error !== 1'b1 || busy !== 1'b0) begin
         n_fail++; $display("FAIL len_big: got err=%b busy=%b want 1/0", cmd_error, busy); end
      n_checks++; if (cmd_length !== 16'h0101) begin n_fail++; $display("FAIL len_big_len: got %h want 0101", cmd_length); end
      settle();
      clear_mon();
      send_dsm(8'h1A);
      end_bytes();
      settle();
      n_checks++; if (dones !== 1 || errs !== 0) begin
         n_fail++; $display("FAIL len_big_recover: got done=%0d err=%0d want 1/0", dones, errs); end
   endtask

   task automatic test_sync_bytes_as_data();
      clear_mon();
      send_byte(8'hAA); send_byte(8'h55); send_byte(8'h10); send_byte(8'h00); send_byte(8'h02);
      send_byte(8'hAA); send_byte(8'h55); send_byte(8'h11);
      end_bytes();
      settle();
      n_checks++; if (dones !== 1 || np !== 2 || pd[0] !== 8'hAA || pd[1] !== 8'h55 || pi[1] !== 16'd1) begin
         n_fail++; $display("FAIL sync_data: got done=%0d n=%0d %h %h@%0d want 1 2 aa 55@1", dones, np, pd[0], pd[1], pi[1]); end
   endtask

   task automatic test_back_to_back();
      clear_mon();
      send_byte(8'hAA); send_byte(8'h55); send_byte(8'hFF);
      send_byte(8'h00); send_byte(8'h00); send_byte(8'hFF);
      send_dsm(8'h1A);
      end_bytes();
      settle();
      n_checks++; if (dones !== 2 || errs !== 0 || starts !== 2) begin
         n_fail++; $display("FAIL b2b: got done=%0d err=%0d start=%0d want 2/0/2", dones, errs, starts); end
   endtask

   task automatic test_timeout();
      int k;
      clear_mon();
      send_byte(8'hAA); send_byte(8'h55); send_byte(8'h0A); send_byte(8'h00); send_byte(8'h03);
      send_byte(8'h01);
      end_bytes();
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL tmo_busy_mid: got %b want 1", busy); end
      k = 0;
      while (cmd_error !== 1'b1 && k < 3 * TMO) begin
         @(negedge clk);
         k++;
      end
      n_checks++; if (k !== TMO) begin n_fail++; $display("FAIL tmo_cycles: got %0d want %0d", k, TMO); end
      n_checks++; if (cmd_error !== 1'b1 || busy !== 1'b0) begin
         n_fail++; $display("FAIL tmo_abort: got err=%b busy=%b want 1/0", cmd_error, busy); end
      settle();
      n_checks++; if (errs !== 1 || dones !== 0) begin
         n_fail++; $display("FAIL tmo_cnt: got err=%0d done=%0d want 1/0", errs, dones); end
   endtask

   task automatic test_reset_mid_frame();
      clear_mon();
      send_byte(8'hAA); send_byte(8'h55); send_byte(8'hFE); send_byte(8'h00); send_byte(8'h05);
      send_byte(8'h01);
      end_bytes();
      n_checks++; if (payload_valid !== 1'b1 || busy !== 1'b1) begin
         n_fail++; $display("FAIL rst_pre: got pv=%b busy=%b want 1/1", payload_valid, busy); end
      #1 rst_n = 1'b0;
      #1;
      n_checks++; if ({payload_valid, busy, cmd_done, cmd_error, cmd_start} !== 5'b0 ||
                      {cmd_out, cmd_length, payload_data, payload_index} !== 48'h0) begin
         n_fail++; $display("FAIL rst_mid: got %b %h want all 0", {payload_valid, busy, cmd_done, cmd_error, cmd_start},
                            {cmd_out, cmd_length, payload_data, payload_index}); end
      @(negedge clk);
      rst_n = 1'b1;
      settle();
      clear_mon();
      send_dsm(8'h1A);
      end_bytes();
      settle();
      n_checks++; if (dones !== 1 || errs !== 0) begin
         n_fail++; $display("FAIL rst_recover: got done=%0d err=%0d want 1/0", dones, errs); end
   endtask

   initial begin
      test_reset();
      test_heartbeat();
      test_pwm();
      test_dsm();
      test_resync();
      test_len_too_big();
      test_sync_bytes_as_data();
      test_back_to_back();
      test_timeout();
      test_reset_mid_frame();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
